alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DW, default 8, ALU operand width.
REQ-002 Parameter CW, default 4, ALU command width.
REQ-003 Parameter LAT, default 2, ALU cycles from issue edge to result capture edge (LAT >= 1).
REQ-004 Parameter MUL_LAT, default 3, capture latency used instead of LAT for multiply commands (MODE=1, CMD=9 or 10).
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 REQ_VALID  in  2  per-requester request valid; bit i = requester i.
REQ-008 REQ_READY  out  2  per-requester request accept.
REQ-009 REQ_OPA, REQ_OPB  in  2*DW each  operands; slice [i*DW +: DW] = requester i.
REQ-010 REQ_CMD  in  2*CW; REQ_MODE, REQ_CIN  in  2; REQ_INP_VALID  in  4 (2 bits per requester).
REQ-011 RSP_VALID  out  2  response valid, bit i for requester i; RSP_READY  in  2  response accept.
REQ-012 RSP_RES  out  2*DW  captured ALU result; RSP_FLAGS  out  6  {COUT,OFLOW,G,E,L,ERR}.
REQ-013 ALU_CE  out  1; ALU_INP_VALID  out  2; ALU_OPA, ALU_OPB  out  DW; ALU_CMD  out  CW; ALU_MODE, ALU_CIN  out  1.
REQ-014 ALU_RES  in  2*DW; ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR  in  1 each.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-016 IDLE: if any REQ_VALID, grant one requester; REQ_READY asserted combinationally for granted requester only; handshake = REQ_VALID & REQ_READY.
REQ-017 On handshake edge: capture granted requester's OPA, OPB, CMD, MODE, CIN, INP_VALID and grant id; IDLE -> ISSUE.
REQ-018 ISSUE (exactly 1 cycle): ALU_CE=1, ALU_INP_VALID = captured value, captured fields on ALU_*; load counter with MUL_LAT if MODE=1 and CMD in {9,10}, else LAT; -> WAIT.
REQ-019 All states except ISSUE: ALU_CE=0, ALU_INP_VALID=0; ALU_OPA/OPB/CMD/MODE/CIN hold last value.
REQ-020 WAIT: counter decrements each cycle; on edge where it reaches 0, capture ALU_RES and six flags into RSP_RES/RSP_FLAGS; -> RESP.
REQ-021 Latency: RSP_VALID rises L+1 edges after handshake edge (L = selected latency); LAT=2 gives 3.
REQ-022 RESP: RSP_VALID[grant]=1, other bit 0; RSP_RES/RSP_FLAGS stable until RSP_VALID & RSP_READY; then -> IDLE.
REQ-023 RSP_READY already high on entry: RSP_VALID high exactly one cycle.
REQ-024 REQ_READY=0 in ISSUE, WAIT, RESP; next grant earliest the cycle after response handshake.
REQ-025 Arbitration (default): round-robin; on simultaneous requests the requester not granted last wins; single requester always wins.
REQ-026 REQ_VALID withdrawn before grant: no effect, no capture.
REQ-027 REQ_INP_VALID=00 or any CMD: forwarded unchanged; arbiter never interprets or blocks operations.

Reset
REQ-028 RST asserted: FSM -> IDLE immediately; REQ_READY=0, RSP_VALID=0, ALU_CE=0, ALU_INP_VALID=0, ALU_OPA/OPB/CMD/MODE/CIN=0, RSP_RES=0, RSP_FLAGS=0, counter=0, round-robin pointer favours requester 0.
REQ-029 Reset mid-operation: in-flight operation discarded, no response generated; after release, requesters re-arbitrate from IDLE.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins simultaneous requests, pointer unused.
REQ-031 Macro undefined: round-robin per REQ-025; all other behaviour identical.

Verification
REQ-032 Single request: req0 OPA=8'h0F, OPB=8'h01, MODE=1, CMD=0, INP_VALID=11 -> one ALU_CE pulse; RSP_VALID[0] 3 edges after handshake, RSP_RES=16'h0010.
REQ-033 Multiply: req1 MODE=1, CMD=9, OPA=3, OPB=4 -> RSP_VALID[1] 4 edges after handshake, RSP_RES per ALU model.
REQ-034 Contention: REQ_VALID=11 held for 4 ops -> grants 0,1,0,1 (round-robin); with ALU_ARB_FIXED_PRIO_EN grants 0,0,0,0.
REQ-035 Backpressure: RSP_READY[0]=0 for 5 cycles -> RSP_VALID[0] and RSP_RES held stable, REQ_READY=00, no ALU_CE.
REQ-036 Reset in WAIT: RST high 1 cycle -> ALU_CE=0, RSP_VALID=00 immediately; no response for discarded op; next request granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
// slave = arbiter side, master = requesters + ALU (testbench side).
interface alu_arbiter_if #(
    parameter int DW = 8,
    parameter int CW = 4
);
    logic [1:0]      REQ_VALID;
    logic [1:0]      REQ_READY;
    logic [2*DW-1:0] REQ_OPA;
    logic [2*DW-1:0] REQ_OPB;
    logic [2*CW-1:0] REQ_CMD;
    logic [1:0]      REQ_MODE;
    logic [1:0]      REQ_CIN;
    logic [3:0]      REQ_INP_VALID;

    logic [1:0]      RSP_VALID;
    logic [1:0]      RSP_READY;
    logic [2*DW-1:0] RSP_RES;
    logic [5:0]      RSP_FLAGS;

    logic            ALU_CE;
    logic [1:0]      ALU_INP_VALID;
    logic [DW-1:0]   ALU_OPA;
    logic [DW-1:0]   ALU_OPB;
    logic [CW-1:0]   ALU_CMD;
    logic            ALU_MODE;
    logic            ALU_CIN;
    logic [2*DW-1:0] ALU_RES;
    logic            ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;

    modport slave (
        input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID,
        input  RSP_READY,
        input  ALU_RES, ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR,
        output REQ_READY, RSP_VALID, RSP_RES, RSP_FLAGS,
        output ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN
    );

    modport master (
        output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID,
        output RSP_READY,
        output ALU_RES, ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR,
        input  REQ_READY, RSP_VALID, RSP_RES, RSP_FLAGS,
        input  ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter serialising operations onto one pipelined ALU, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int LAT     = 2,
    parameter int MUL_LAT = 3
) (
    input logic         CLK,
    input logic         RST,
    alu_arbiter_if.slave bus
);
    localparam int LMAX  = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    localparam int CNT_W = $clog2(LMAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            gid_q, gid_d;
    logic [DW-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [CW-1:0]   cmd_q, cmd_d;
    logic            mode_q, mode_d, cin_q, cin_d;
    logic            ce_q, ce_d;
    logic [1:0]      alu_iv_q, alu_iv_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [2*DW-1:0] rsp_res_q, rsp_res_d;
    logic [5:0]      rsp_flags_q, rsp_flags_d;
    logic            grant;
    logic [1:0]      req_ready;
    logic            is_mul;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant = ~bus.REQ_VALID[0];
`else
    logic last_q, last_d;  // requester granted most recently
    assign grant = (&bus.REQ_VALID) ? ~last_q : ~bus.REQ_VALID[0];
`endif

    assign req_ready = (state_q == IDLE && !RST) ?
                       ((grant ? 2'b10 : 2'b01) & bus.REQ_VALID) : 2'b00;
    assign is_mul    = mode_q && (cmd_q == CW'(9) || cmd_q == CW'(10));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gid_d       = gid_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cmd_d       = cmd_q;
        mode_d      = mode_q;
        cin_d       = cin_q;
        ce_d        = 1'b0;
        alu_iv_d    = 2'b00;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: if (|req_ready) begin
                gid_d    = grant;
                opa_d    = grant ? bus.REQ_OPA[2*DW-1:DW] : bus.REQ_OPA[DW-1:0];
                opb_d    = grant ? bus.REQ_OPB[2*DW-1:DW] : bus.REQ_OPB[DW-1:0];
                cmd_d    = grant ? bus.REQ_CMD[2*CW-1:CW] : bus.REQ_CMD[CW-1:0];
                mode_d   = bus.REQ_MODE[grant];
                cin_d    = bus.REQ_CIN[grant];
                alu_iv_d = grant ? bus.REQ_INP_VALID[3:2] : bus.REQ_INP_VALID[1:0];
                ce_d     = 1'b1;
                state_d  = ISSUE;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_d   = grant;
`endif
            end
            ISSUE: begin
                cnt_d   = is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
                state_d = WAIT;
            end
            WAIT: begin
                // capture on the edge where the count would reach zero
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d       = '0;
                    rsp_res_d   = bus.ALU_RES;
                    rsp_flags_d = {bus.ALU_COUT, bus.ALU_OFLOW, bus.ALU_G,
                                   bus.ALU_E, bus.ALU_L, bus.ALU_ERR};
                    rsp_valid_d = gid_q ? 2'b10 : 2'b01;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: if (|(rsp_valid_q & bus.RSP_READY)) begin
                rsp_valid_d = 2'b00;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gid_q       <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            ce_q        <= 1'b0;
            alu_iv_q    <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gid_q       <= gid_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            ce_q        <= ce_d;
            alu_iv_q    <= alu_iv_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.REQ_READY     = req_ready;
    assign bus.RSP_VALID     = rsp_valid_q;
    assign bus.RSP_RES       = rsp_res_q;
    assign bus.RSP_FLAGS     = rsp_flags_q;
    assign bus.ALU_CE        = ce_q;
    assign bus.ALU_INP_VALID = alu_iv_q;
    assign bus.ALU_OPA       = opa_q;
    assign bus.ALU_OPB       = opb_q;
    assign bus.ALU_CMD       = cmd_q;
    assign bus.ALU_MODE      = mode_q;
    assign bus.ALU_CIN       = cin_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps plus randomized ops against a
// behavioural model (grant rule, latency rule, ALU function) with a latency-sensitive ALU.
module tb_alu_arbiter;
    localparam int DW = 8;
    localparam int CW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    alu_arbiter_if #(.DW(DW), .CW(CW)) bus ();
    alu_arbiter #(.DW(DW), .CW(CW), .LAT(2), .MUL_LAT(3)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int n_checks = 0;
    int n_err    = 0;
    int last_gnt = 1;
    int obs_gid  = 0;
    logic [15:0] obs_res;

    logic [7:0] m_a [2];
    logic [7:0] m_b [2];
    logic [3:0] m_cmd [2];
    logic       m_mode [2];
    logic       m_cin [2];
    logic [1:0] m_iv [2];

    // Result {COUT,OFLOW,G,E,L,ERR,RES[15:0]} of the ALU model
    function automatic logic [21:0] alu_fn(logic mode, logic [3:0] cmd, logic [7:0] a,
                                           logic [7:0] b, logic cin, logic [1:0] iv);
        logic [15:0] r;
        logic [5:0]  f;
        if (mode) begin
            case (cmd)
                4'd0:    r = 16'(a) + 16'(b);
                4'd1:    r = 16'(a) - 16'(b);
                4'd2:    r = 16'(a) + 16'(b) + 16'(cin);
                4'd9:    r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
                4'd10:   r = (16'(a) << 1) * 16'(b);
                default: r = {a, b} ^ 16'h5a5a;
            endcase
        end else begin
            case (cmd)
                4'd0:    r = {8'h00, a & b};
                4'd1:    r = {8'h00, a | b};
                default: r = {b, a};
            endcase
        end
        f = {r[8], ^r, a > b, a == b, a < b, iv != 2'b11};
        return {f, r};
    endfunction

    function automatic int lat_of(logic mode, logic [3:0] cmd);
        return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 3 : 2;
    endfunction

    function automatic int predict(logic [1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return v[0] ? 0 : 1;
`else
        if (v == 2'b11) return (last_gnt == 0) ? 1 : 0;
        return v[0] ? 0 : 1;
`endif
    endfunction

    // ALU model: output is correct only during the cycle its latency elapses
    logic [3:0]  alu_age = 4'd0;
    logic [3:0]  alu_lat = 4'd2;
    logic [21:0] alu_out = 22'd0;
    logic [21:0] alu_sel;
    always @(posedge CLK) begin
        if (bus.ALU_CE) begin
            alu_age <= 4'd1;
            alu_lat <= 4'(lat_of(bus.ALU_MODE, bus.ALU_CMD));
            alu_out <= alu_fn(bus.ALU_MODE, bus.ALU_CMD, bus.ALU_OPA, bus.ALU_OPB,
                              bus.ALU_CIN, bus.ALU_INP_VALID);
        end else if (alu_age != 4'd0 && alu_age != 4'd15) begin
            alu_age <= alu_age + 4'd1;
        end
    end
    assign alu_sel     = (alu_age == alu_lat) ? alu_out : ~alu_out;
    assign bus.ALU_RES = alu_sel[15:0];
    assign {bus.ALU_COUT, bus.ALU_OFLOW, bus.ALU_G, bus.ALU_E, bus.ALU_L, bus.ALU_ERR} = alu_sel[21:16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] cmd, input logic mode, input logic cin,
                           input logic [1:0] iv);
        m_a[i] = a; m_b[i] = b; m_cmd[i] = cmd; m_mode[i] = mode; m_cin[i] = cin; m_iv[i] = iv;
        bus.REQ_OPA[i*DW +: DW]     = a;
        bus.REQ_OPB[i*DW +: DW]     = b;
        bus.REQ_CMD[i*CW +: CW]     = cmd;
        bus.REQ_MODE[i]             = mode;
        bus.REQ_CIN[i]              = cin;
        bus.REQ_INP_VALID[i*2 +: 2] = iv;
    endtask

    // One complete transaction from grant to response handshake; hold = cycles RSP_READY stays low
    task automatic run_txn(input string tag, input bit drop, input int hold);
        int exp_gid, exp_lat, n, ce, busy, bad;
        logic [1:0]  exp_v;
        logic [21:0] exp_r;
        bit got;
        #1;
        exp_gid = predict(bus.REQ_VALID);
        exp_v   = (exp_gid == 1) ? 2'b10 : 2'b01;
        got     = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (|(bus.REQ_VALID & bus.REQ_READY)) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_grant_seen"}, 32'(got), 32'd1);
        if (!got) return;
        obs_gid = bus.REQ_READY[1] ? 1 : 0;
        chk({tag, "_req_ready"}, 32'(bus.REQ_READY), 32'(exp_v));
        last_gnt = exp_gid;
        exp_r    = alu_fn(m_mode[exp_gid], m_cmd[exp_gid], m_a[exp_gid], m_b[exp_gid],
                          m_cin[exp_gid], m_iv[exp_gid]);
        exp_lat  = lat_of(m_mode[exp_gid], m_cmd[exp_gid]);
        bus.RSP_READY = (hold == 0) ? 2'b11 : 2'b00;
        tick();
        if (drop) bus.REQ_VALID[exp_gid] = 1'b0;
        #1;
        n = 0; ce = 0; busy = 0;
        while (n < 20 && bus.RSP_VALID == 2'b00) begin
            ce += int'(bus.ALU_CE);
            if (bus.REQ_READY != 2'b00) busy++;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat + 1));
        chk({tag, "_ce_pulses"}, 32'(ce), 32'd1);
        chk({tag, "_busy_ready"}, 32'(busy), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.RSP_VALID), 32'(exp_v));
        chk({tag, "_rsp_res"}, 32'(bus.RSP_RES), 32'(exp_r[15:0]));
        chk({tag, "_rsp_flags"}, 32'(bus.RSP_FLAGS), 32'(exp_r[21:16]));
        obs_res = bus.RSP_RES;
        if (hold > 0) begin
            bad = 0;
            for (int h = 0; h < hold; h++) begin
                tick();
                if (bus.RSP_VALID != exp_v || bus.RSP_RES != exp_r[15:0] ||
                    bus.RSP_FLAGS != exp_r[21:16] || bus.ALU_CE || bus.REQ_READY != 2'b00)
                    bad++;
                // a request that comes and goes while busy must leave no trace
                if (drop && hold >= 3 && h == 1) bus.REQ_VALID[1-exp_gid] = 1'b1;
                if (drop && hold >= 3 && h == hold - 1) bus.REQ_VALID[1-exp_gid] = 1'b0;
            end
            chk({tag, "_hold_stable"}, 32'(bad), 32'd0);
            bus.RSP_READY = 2'b11;
        end
        tick();
        chk({tag, "_rsp_drop"}, 32'(bus.RSP_VALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] gseq;
        int quiet;
        logic [1:0] v;
        logic [3:0] c;

        bus.REQ_VALID = 2'b00; bus.REQ_OPA = '0; bus.REQ_OPB = '0; bus.REQ_CMD = '0;
        bus.REQ_MODE = 2'b00; bus.REQ_CIN = 2'b00; bus.REQ_INP_VALID = 4'h0;
        bus.RSP_READY = 2'b00;
        RST = 1'b1;
        repeat (3) tick();
        bus.REQ_VALID = 2'b11;
        #1;
        chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
        chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("rst_alu_ce", 32'(bus.ALU_CE), 32'd0);
        chk("rst_alu_iv", 32'(bus.ALU_INP_VALID), 32'd0);
        chk("rst_alu_ops", {bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD, bus.ALU_MODE, bus.ALU_CIN}, 32'd0);
        chk("rst_rsp_res", 32'(bus.RSP_RES), 32'd0);
        chk("rst_rsp_flags", 32'(bus.RSP_FLAGS), 32'd0);
        bus.REQ_VALID = 2'b00;
        RST = 1'b0;
        tick();

        // single add from requester 0
        set_req(0, 8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 2'b11);
        bus.REQ_VALID = 2'b01;
        run_txn("single", 1'b1, 0);
        chk("single_res_const", 32'(obs_res), 32'h0010);
        bus.REQ_VALID = 2'b00;

        // multiply from requester 1
        set_req(1, 8'd3, 8'd4, 4'd9, 1'b1, 1'b0, 2'b11);
        bus.REQ_VALID = 2'b10;
        run_txn("mul", 1'b1, 0);
        chk("mul_res_const", 32'(obs_res), 32'h0014);
        bus.REQ_VALID = 2'b00;

        // contention with both requests held for four ops
        set_req(0, 8'h21, 8'h13, 4'd1, 1'b1, 1'b0, 2'b11);
        set_req(1, 8'h07, 8'h05, 4'd10, 1'b1, 1'b1, 2'b01);
        bus.REQ_VALID = 2'b11;
        gseq = 4'h0;
        for (int k = 0; k < 4; k++) begin
            run_txn("cont", 1'b0, 0);
            gseq = {gseq[2:0], 1'(obs_gid)};
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("cont_grant_order", 32'(gseq), 32'b0000);
`else
        chk("cont_grant_order", 32'(gseq), 32'b0101);
`endif
        bus.REQ_VALID = 2'b00;

        // backpressure on requester 0 with a transient request from requester 1
        set_req(0, 8'hA5, 8'h3C, 4'd2, 1'b1, 1'b1, 2'b10);
        set_req(1, 8'h11, 8'h22, 4'd0, 1'b0, 1'b0, 2'b11);
        bus.REQ_VALID = 2'b01;
        run_txn("bp", 1'b1, 5);
        bus.REQ_VALID = 2'b00;
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.ALU_CE || bus.RSP_VALID != 2'b00) quiet++;
        end
        chk("withdrawn_no_op", 32'(quiet), 32'd0);

        // reset while waiting on the ALU
        set_req(0, 8'h44, 8'h55, 4'd0, 1'b1, 1'b0, 2'b11);
        bus.REQ_VALID = 2'b01;
        #1;
        chk("rstw_grant", 32'(bus.REQ_READY), 32'b01);
        tick();
        bus.REQ_VALID = 2'b00;
        tick();
        tick();
        RST = 1'b1;
        #1;
        chk("rstw_ce", 32'(bus.ALU_CE), 32'd0);
        chk("rstw_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("rstw_rsp_res", 32'(bus.RSP_RES), 32'd0);
        last_gnt = 1;
        tick();
        RST = 1'b0;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.RSP_VALID != 2'b00 || bus.ALU_CE) quiet++;
        end
        chk("rstw_no_rsp", 32'(quiet), 32'd0);
        set_req(0, 8'h09, 8'h06, 4'd0, 1'b0, 1'b0, 2'b11);
        set_req(1, 8'h0A, 8'h0B, 4'd1, 1'b1, 1'b0, 2'b11);
        bus.REQ_VALID = 2'b11;
        run_txn("post_rst", 1'b1, 0);
        chk("post_rst_gid", 32'(obs_gid), 32'd0);
        bus.REQ_VALID = 2'b00;

        // randomized operations
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) begin
                c = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) c = 4'(9 + $urandom_range(0, 1));
                set_req(i, 8'($urandom), 8'($urandom), c, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end
            v = 2'($urandom_range(1, 3));
            bus.REQ_VALID = v;
            run_txn("rand", 1'b1, $urandom_range(0, 2));
            bus.REQ_VALID = 2'b00;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
